// File: rtl/thor2023_dcache_wrway_ctrl.sv
// Per-bank write strobe and write-way selection for the Thor2023 4-way data cache.
// Store hits write the hit way; miss fills write a pseudo-random victim taken from a 17-bit LFSR.
module thor2023_dcache_wrway_ctrl #(
   parameter logic [6:0]  ST_LOOKUP    = 7'd1,
   parameter logic [6:0]  ST_STORE_ACK = 7'd2,
   parameter logic [3:0]  FN_STORE     = 4'h1,
   parameter int unsigned ACR_C        = 3,
   parameter logic [16:0] LFSR_SEED    = 17'h00001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  state,
   input  logic        wr_dc,
   input  logic        ack,
   input  logic [3:0]  func,
   input  logic        dce,
   input  logic [3:0]  hit,
   input  logic        hit2,
   input  logic        inv,
   input  logic [3:0]  acr,
   input  logic        eaeo,
   input  logic        daeo,
   output logic        wr,
   output logic [1:0]  rway,
   output logic [1:0]  wway,
   output logic [16:0] lfsr_o
);

   logic [16:0] lfsr_q, lfsr_d;
   logic [1:0]  wway_q, wway_d;
   logic        lookup_here;
   logic        fill_wr;
   logic        store_wr;
   logic        write_allowed;

   // x^17 + x^14 + 1, maximal length; free-running so victim choice decorrelates from access pattern.
   always_comb begin
      lfsr_d = {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]};
   end

   // Highest-index hit wins; a well-formed tag array never reports more than one hit.
   always_comb begin
      rway = 2'd0;
      if (hit[3]) begin
         rway = 2'd3;
      end else if (hit[2]) begin
         rway = 2'd2;
      end else if (hit[1]) begin
         rway = 2'd1;
      end
   end

   assign lookup_here = (state == ST_LOOKUP) && eaeo && dce;

   // The write way is latched at lookup and held through the later fill or store write.
   always_comb begin
      wway_d = wway_q;
      if (lookup_here) begin
         if (hit2 && (|hit)) begin
            wway_d = rway;
         end else if (!hit2) begin
            wway_d = lfsr_q[1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
         wway_q <= 2'd0;
      end else begin
         lfsr_q <= lfsr_d;
         wway_q <= wway_d;
      end
   end

   assign write_allowed = !inv && dce && acr[ACR_C];
   assign fill_wr       = wr_dc && daeo;
   assign store_wr      = (state == ST_STORE_ACK) && ack && (func == FN_STORE) && hit2 && eaeo;

   assign wr     = write_allowed && (fill_wr || store_wr);
   assign wway   = wway_q;
   assign lfsr_o = lfsr_q;

endmodule

// File: tb/tb_thor2023_dcache_wrway_ctrl.sv
// Self-checking bench for thor2023_dcache_wrway_ctrl: expected values are queued at stimulus
// time and popped against DUT outputs sampled on the falling clock edge.
module tb_thor2023_dcache_wrway_ctrl;

   localparam logic [6:0]  ST_LOOKUP    = 7'd1;
   localparam logic [6:0]  ST_STORE_ACK = 7'd2;
   localparam logic [3:0]  FN_STORE     = 4'h1;
   localparam logic [16:0] LFSR_SEED    = 17'h00001;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  state;
   logic        wr_dc;
   logic        ack;
   logic [3:0]  func;
   logic        dce;
   logic [3:0]  hit;
   logic        hit2;
   logic        inv;
   logic [3:0]  acr;
   logic        eaeo;
   logic        daeo;
   logic        wr;
   logic [1:0]  rway;
   logic [1:0]  wway;
   logic [16:0] lfsr_o;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [16:0] lfsr_m;

   thor2023_dcache_wrway_ctrl dut (
      .clk    (clk),
      .rst    (rst),
      .state  (state),
      .wr_dc  (wr_dc),
      .ack    (ack),
      .func   (func),
      .dce    (dce),
      .hit    (hit),
      .hit2   (hit2),
      .inv    (inv),
      .acr    (acr),
      .eaeo   (eaeo),
      .daeo   (daeo),
      .wr     (wr),
      .rway   (rway),
      .wway   (wway),
      .lfsr_o (lfsr_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference LFSR model
   always @(posedge clk) begin
      if (rst) lfsr_m <= LFSR_SEED;
      else     lfsr_m <= {lfsr_m[15:0], lfsr_m[16] ^ lfsr_m[13]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic sb_check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_underflow"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check(tag, obs, e);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      state = 7'd0; wr_dc = 1'b0; ack = 1'b0; func = 4'h0; dce = 1'b0;
      hit = 4'h0; hit2 = 1'b0; inv = 1'b0; acr = 4'h0; eaeo = 1'b0; daeo = 1'b0;
   endtask

   task automatic wait_lfsr_low(input logic [1:0] v);
      for (int i = 0; i < 300; i++) begin
         if (lfsr_m[1:0] == v) return;
         tick();
      end
      check("lfsr_wait_timeout", 32'(lfsr_m[1:0]), 32'(v));
   endtask

   task automatic drive_lookup(input logic e, input logic h2, input logic [3:0] h);
      state = ST_LOOKUP; dce = 1'b1; eaeo = e; hit2 = h2; hit = h;
   endtask

   function automatic logic model_wr(input logic [6:0] s, input logic wdc, input logic a,
                                     input logic [3:0] f, input logic d, input logic h2,
                                     input logic iv, input logic [3:0] ac, input logic e,
                                     input logic da);
      logic fill_c, store_c;
      fill_c  = wdc && da;
      store_c = (s == ST_STORE_ACK) && a && (f == FN_STORE) && h2 && e;
      if (iv || !d || !ac[3]) return 1'b0;
      return fill_c || store_c;
   endfunction

   function automatic logic [1:0] model_rway(input logic [3:0] h);
      if (h[3]) return 2'd3;
      if (h[2]) return 2'd2;
      if (h[1]) return 2'd1;
      return 2'd0;
   endfunction

   initial begin
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      tick();
      tick();

      // reset state and LFSR sequence
      sb_push(32'h00001); sb_check("rst_lfsr", 32'(lfsr_o));
      sb_push(32'd0);     sb_check("rst_wway", 32'(wway));
      rst = 1'b0;
      tick();
      sb_push(32'h00002); sb_check("lfsr_1", 32'(lfsr_o));
      repeat (12) tick();
      sb_push(32'h02000); sb_check("lfsr_13", 32'(lfsr_o));
      tick();
      sb_push(32'h04001); sb_check("lfsr_14", 32'(lfsr_o));

      // miss: victim from LFSR
      wait_lfsr_low(2'b10);
      drive_lookup(1'b1, 1'b0, 4'h0);
      sb_push(32'd2);
      tick();
      sb_check("miss_wway", 32'(wway));
      idle_inputs();

      // miss with eaeo=0: hold
      wait_lfsr_low(2'b01);
      drive_lookup(1'b0, 1'b0, 4'h0);
      sb_push(32'd2);
      tick();
      sb_check("miss_eaeo0_hold", 32'(wway));
      idle_inputs();

      wait_lfsr_low(2'b01);
      drive_lookup(1'b1, 1'b0, 4'h0);
      sb_push(32'd1);
      tick();
      sb_check("miss_wway1", 32'(wway));
      idle_inputs();

      // store hit
      drive_lookup(1'b1, 1'b1, 4'b0110);
      #1;
      sb_push(32'd2); sb_check("rway_0110", 32'(rway));
      sb_push(32'd2);
      tick();
      sb_check("hit_wway", 32'(wway));
      idle_inputs();
      hit = 4'b0001; #1; sb_push(32'd0); sb_check("rway_0001", 32'(rway));
      hit = 4'b1000; #1; sb_push(32'd3); sb_check("rway_1000", 32'(rway));
      hit = 4'b1010; #1; sb_push(32'd3); sb_check("rway_1010", 32'(rway));
      hit = 4'b0000; #1; sb_push(32'd0); sb_check("rway_0000", 32'(rway));
      @(negedge clk);

      // hit2=1 with empty hit vector, and dce=0: both hold
      drive_lookup(1'b1, 1'b1, 4'h0);
      sb_push(32'd2);
      tick();
      sb_check("hit2_nohit_hold", 32'(wway));
      drive_lookup(1'b1, 1'b1, 4'b1000);
      dce = 1'b0;
      sb_push(32'd2);
      tick();
      sb_check("dce0_hold", 32'(wway));
      idle_inputs();

      // fill write strobe
      wr_dc = 1'b1; daeo = 1'b1; dce = 1'b1; acr = 4'b1000; inv = 1'b0;
      #1; sb_push(32'd1); sb_check("fill_wr", 32'(wr));
      daeo = 1'b0; #1; sb_push(32'd0); sb_check("fill_daeo0", 32'(wr));
      daeo = 1'b1; inv = 1'b1; #1; sb_push(32'd0); sb_check("fill_inv", 32'(wr));
      inv = 1'b0; acr = 4'b0000; #1; sb_push(32'd0); sb_check("fill_acr0", 32'(wr));
      acr = 4'b0111; #1; sb_push(32'd0); sb_check("fill_acr0111", 32'(wr));
      acr = 4'b1000; dce = 1'b0; #1; sb_push(32'd0); sb_check("fill_dce0", 32'(wr));
      @(negedge clk);
      idle_inputs();

      // store update strobe
      state = ST_STORE_ACK; ack = 1'b1; func = FN_STORE; hit2 = 1'b1; eaeo = 1'b1;
      dce = 1'b1; acr = 4'b1000;
      #1; sb_push(32'd1); sb_check("store_wr", 32'(wr));
      func = 4'h0; #1; sb_push(32'd0); sb_check("store_func0", 32'(wr));
      func = FN_STORE; ack = 1'b0; #1; sb_push(32'd0); sb_check("store_ack0", 32'(wr));
      ack = 1'b1; hit2 = 1'b0; #1; sb_push(32'd0); sb_check("store_hit2_0", 32'(wr));
      hit2 = 1'b1; eaeo = 1'b0; #1; sb_push(32'd0); sb_check("store_eaeo0", 32'(wr));
      eaeo = 1'b1; state = ST_LOOKUP; #1; sb_push(32'd0); sb_check("store_wrong_state", 32'(wr));
      @(negedge clk);

      // simultaneous fill and store: single strobe, wway untouched
      state = ST_STORE_ACK; wr_dc = 1'b1; daeo = 1'b1; hit = 4'b1000;
      #1; sb_push(32'd1); sb_check("both_wr", 32'(wr));
      sb_push(32'd2);
      tick();
      sb_check("both_wway_hold", 32'(wway));
      idle_inputs();

      // randomized combinational checks
      for (int i = 0; i < 40; i++) begin
         state = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : ST_STORE_ACK;
         wr_dc = 1'($urandom_range(0, 1)); ack = 1'($urandom_range(0, 1));
         func = ($urandom_range(0, 1) == 0) ? FN_STORE : 4'($urandom_range(0, 15));
         dce = 1'($urandom_range(0, 3) != 0); hit = 4'($urandom_range(0, 15));
         hit2 = 1'($urandom_range(0, 1)); inv = 1'($urandom_range(0, 3) == 0);
         acr = 4'($urandom_range(0, 15)); eaeo = 1'($urandom_range(0, 1));
         daeo = 1'($urandom_range(0, 1));
         #1;
         sb_push(32'(model_wr(state, wr_dc, ack, func, dce, hit2, inv, acr, eaeo, daeo)));
         sb_check("rand_wr", 32'(wr));
         sb_push(32'(model_rway(hit)));
         sb_check("rand_rway", 32'(rway));
         @(negedge clk);
      end
      idle_inputs();

      // set wway=3, free-run, then reset mid-run
      drive_lookup(1'b1, 1'b1, 4'b1000);
      sb_push(32'd3);
      tick();
      sb_check("wway3", 32'(wway));
      idle_inputs();
      repeat (50) tick();
      sb_push(32'(lfsr_m)); sb_check("lfsr_free_run", 32'(lfsr_o));
      sb_push(32'd3);       sb_check("wway3_hold", 32'(wway));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb_push(32'h00001); sb_check("midrst_lfsr", 32'(lfsr_o));
      sb_push(32'd0);     sb_check("midrst_wway", 32'(wway));

      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
